// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART arbiter package: FSM state encoding and default data width.
package uart_tx_arbiter_pkg;

    localparam int DEFAULT_DATA_BITS = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE       = 2'd0;
    localparam state_t ST_WRITE      = 2'd1;
    localparam state_t ST_WAIT_START = 2'd2;
    localparam state_t ST_WAIT_DONE  = 2'd3;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Round-robin priority search: first requester after Last_Grant, wrapping,
// with Last_Grant itself checked last.
module rr_select #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         Req,
    input  logic [$clog2(NUM_REQ)-1:0] Last_Grant,
    output logic [$clog2(NUM_REQ)-1:0] Winner,
    output logic                       Any_Valid
);

    localparam int GW = $clog2(NUM_REQ);

    logic [GW-1:0] idx;

    always_comb begin
        Winner    = '0;
        Any_Valid = 1'b0;
        idx       = Last_Grant;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (idx == GW'(NUM_REQ - 1)) ? '0 : idx + GW'(1);
            if (!Any_Valid && Req[idx]) begin
                Any_Valid = 1'b1;
                Winner    = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding single bytes from NUM_REQ requesters into one
// UART transmitter, with a watchdog on the transmitter starting.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_BITS     = DEFAULT_DATA_BITS,
    parameter int START_TIMEOUT = 16
) (
    input  logic                           SysClk,
    input  logic                           Rst_n,
    input  logic [NUM_REQ-1:0]             Req,
    input  logic [NUM_REQ*DATA_BITS-1:0]   Req_Data,
    output logic [NUM_REQ-1:0]             Grant,
    input  logic                           Tx_Busy,
    output logic                           Tx_Write,
    output logic [DATA_BITS-1:0]           Tx_Data,
    output logic                           Timeout_Err,
    output logic [$clog2(NUM_REQ)-1:0]     Last_Grant,
    output state_t                         Fsm_State
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    state_t                state;
    logic [GW-1:0]         win_q;
    logic [GW-1:0]         last_q;
    logic [GW-1:0]         rr_winner;
    logic                  rr_valid;
    logic [CW-1:0]         cnt;
    logic [DATA_BITS-1:0]  data_q;
    logic                  to_q;

    rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
        .Req        (Req),
        .Last_Grant (last_q),
        .Winner     (rr_winner),
        .Any_Valid  (rr_valid)
    );

    always_ff @(posedge SysClk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= ST_IDLE;
            win_q  <= '0;
            last_q <= GW'(NUM_REQ - 1);
            cnt    <= '0;
            data_q <= '0;
            to_q   <= 1'b0;
        end else begin
            to_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!Tx_Busy && rr_valid) begin
                        win_q  <= rr_winner;
                        data_q <= Req_Data[rr_winner*DATA_BITS +: DATA_BITS];
                        state  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    last_q <= win_q;
                    cnt    <= '0;
                    state  <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    // The pulse is registered so it lands on the first IDLE cycle.
                    if (Tx_Busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (cnt == CW'(START_TIMEOUT - 1)) begin
                        to_q  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!Tx_Busy) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake: Tx_Write and the winner's Grant bit are high together for
    // the single WRITE cycle; Tx_Data is stable from selection until the next one.
    always_comb begin
        Grant = '0;
        if (state == ST_WRITE) Grant[win_q] = 1'b1;
    end

    assign Tx_Write    = (state == ST_WRITE);
    assign Tx_Data     = data_q;
    assign Timeout_Err = to_q;
    assign Last_Grant  = last_q;
    assign Fsm_State   = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter against a round-robin model.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int DB = 8;
  localparam int TO = 16;

  logic             SysClk = 1'b0;
  logic             Rst_n;
  logic [NR-1:0]    Req;
  logic [NR*DB-1:0] Req_Data;
  logic [NR-1:0]    Grant;
  logic             Tx_Busy;
  logic             Tx_Write;
  logic [DB-1:0]    Tx_Data;
  logic             Timeout_Err;
  logic [1:0]       Last_Grant;
  state_t           Fsm_State;

  int checks   = 0;
  int failures = 0;
  int n_writes = 0;
  int last_g;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB), .START_TIMEOUT(TO)) dut (
    .SysClk      (SysClk),
    .Rst_n       (Rst_n),
    .Req         (Req),
    .Req_Data    (Req_Data),
    .Grant       (Grant),
    .Tx_Busy     (Tx_Busy),
    .Tx_Write    (Tx_Write),
    .Tx_Data     (Tx_Data),
    .Timeout_Err (Timeout_Err),
    .Last_Grant  (Last_Grant),
    .Fsm_State   (Fsm_State)
  );

  always #5 SysClk = ~SysClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge SysClk) begin
    if (Tx_Write === 1'b1) n_writes++;
    check("grant_onehot0", 32'($onehot0(Grant)), 32'd1);
    check("grant_iff_write", 32'(Grant != '0), 32'(Tx_Write));
  end

  function automatic int rr(input int last, input logic [NR-1:0] m);
    int idx;
    for (int k = 1; k <= NR; k++) begin
      idx = (last + k) % NR;
      if (m[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge SysClk);
    #1;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NR; i++) Req_Data[i*DB +: DB] = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_write(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      tick();
      if (Tx_Write === 1'b1) ok = 1'b1;
    end
    check("write_seen", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    Rst_n   = 1'b0;
    Tx_Busy = 1'b0;
    Req     = '0;
    repeat (2) tick();
    Rst_n  = 1'b1;
    last_g = NR - 1;
    tick();
  endtask

  // One transfer: bench plays the UART (busy after d cycles for len cycles) or never goes busy.
  task automatic txn(input logic [NR-1:0] mask, input bit hold, input bit to, input int d, input int len);
    int            exp_i;
    logic [DB-1:0] exp_b;
    logic [NR-1:0] exp_g;
    bit            ok;
    int            pulses;
    int            pulse_at;
    Req   = mask;
    exp_i = rr(last_g, mask);
    exp_b = Req_Data[exp_i*DB +: DB];
    exp_g = '0;
    exp_g[exp_i] = 1'b1;
    wait_write(ok);
    if (!ok) return;
    check("grant", 32'(Grant), 32'(exp_g));
    check("tx_data", 32'(Tx_Data), 32'(exp_b));
    last_g = exp_i;
    if (!hold) Req[exp_i] = 1'b0;
    randomize_data();
    if (to) begin
      pulses   = 0;
      pulse_at = -1;
      for (int k = 1; k <= TO + 1; k++) begin
        tick();
        if (Timeout_Err === 1'b1) begin
          pulses++;
          pulse_at = k;
        end
      end
      check("timeout_pulses", 32'(pulses), 32'd1);
      check("timeout_cycle", 32'(pulse_at), 32'(TO + 1));
      check("timeout_idle", 32'(Fsm_State), 32'(ST_IDLE));
    end else begin
      repeat (d) tick();
      Tx_Busy = 1'b1;
      repeat (len) tick();
      check("wait_done", 32'(Fsm_State), 32'(ST_WAIT_DONE));
      Tx_Busy = 1'b0;
      tick();
      check("back_idle", 32'(Fsm_State), 32'(ST_IDLE));
    end
    check("tx_data_held", 32'(Tx_Data), 32'(exp_b));
    check("last_grant", 32'(Last_Grant), 32'(exp_i));
  endtask

  initial begin
    int seq[5];
    bit ok;
    seq = '{0, 1, 2, 3, 0};
    Rst_n    = 1'b0;
    Tx_Busy  = 1'b0;
    Req      = '0;
    Req_Data = '0;
    last_g   = NR - 1;
    repeat (2) tick();
    check("rst_write", 32'(Tx_Write), 32'd0);
    check("rst_grant", 32'(Grant), 32'd0);
    check("rst_timeout", 32'(Timeout_Err), 32'd0);
    check("rst_data", 32'(Tx_Data), 32'h00);
    check("rst_state", 32'(Fsm_State), 32'(ST_IDLE));
    check("rst_last", 32'(Last_Grant), 32'd3);
    Rst_n = 1'b1;
    tick();

    randomize_data();
    Req_Data[7:0] = 8'hA5;
    txn(4'b0001, 1'b0, 1'b0, 2, 20);
    check("single_write_count", 32'(n_writes), 32'd1);
    check("single_last", 32'(Last_Grant), 32'd0);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      randomize_data();
      txn(4'b1111, 1'b1, 1'b0, $urandom_range(0, 3), $urandom_range(2, 5));
      check("rr_seq", 32'(Last_Grant), 32'(seq[i]));
    end

    randomize_data();
    txn(4'b0010, 1'b0, 1'b1, 0, 0);

    Tx_Busy = 1'b1;
    Req     = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("busy_blocks_write", 32'(Tx_Write), 32'd0);
    end
    Tx_Busy = 1'b0;
    tick();
    check("write_after_busy", 32'(Tx_Write), 32'd1);
    check("grant_after_busy", 32'(Grant), 32'b0100);
    last_g = 2;
    Req    = 4'b0101;
    tick();
    Tx_Busy = 1'b1;
    repeat (3) tick();
    Tx_Busy = 1'b0;
    tick();
    check("last_is_2", 32'(Last_Grant), 32'd2);
    randomize_data();
    txn(4'b0101, 1'b0, 1'b0, 1, 3);
    check("wrap_grant", 32'(Last_Grant), 32'd0);

    Req = 4'b1000;
    wait_write(ok);
    Req     = '0;
    Tx_Busy = 1'b1;
    repeat (3) tick();
    check("pre_reset_wait_done", 32'(Fsm_State), 32'(ST_WAIT_DONE));
    #1 Rst_n = 1'b0;
    #1;
    check("mid_rst_write", 32'(Tx_Write), 32'd0);
    check("mid_rst_grant", 32'(Grant), 32'd0);
    check("mid_rst_timeout", 32'(Timeout_Err), 32'd0);
    check("mid_rst_data", 32'(Tx_Data), 32'h00);
    check("mid_rst_state", 32'(Fsm_State), 32'(ST_IDLE));
    tick();
    Tx_Busy = 1'b0;
    Rst_n   = 1'b1;
    last_g  = NR - 1;
    tick();
    randomize_data();
    txn(4'b0011, 1'b0, 1'b0, 0, 4);
    check("post_rst_first", 32'(Last_Grant), 32'd0);

    for (int i = 0; i < 24; i++) begin
      randomize_data();
      txn(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 5) == 0), $urandom_range(0, 4), $urandom_range(2, 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
